// File: rtl/conditioned_shift_frontend_pkg.sv
// Shared constants for the conditioned serial front end: channel indices
// within the conditioned bus and default parameter values.
package conditioned_shift_frontend_pkg;

  localparam int unsigned CH_SCLK = 0;
  localparam int unsigned CH_SDI  = 1;
  localparam int unsigned CH_LOAD = 2;
  localparam int unsigned NUM_CH  = 3;

  localparam int unsigned DEF_WIDTH         = 8;
  localparam int unsigned DEF_DEBOUNCE      = 3;
  localparam bit          DEF_SHIFT_ON_FALL = 1'b0;
  localparam bit          DEF_LSB_FIRST     = 1'b0;

endpackage

// File: rtl/input_conditioner_p.sv
// One input channel: two-flop synchroniser, debounce counter and registered
// single-cycle rise/fall pulses on each accepted level change.
module input_conditioner_p
  import conditioned_shift_frontend_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  output logic cond,
  output logic pos,
  output logic neg
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      cond <= 1'b0;
      pos  <= 1'b0;
      neg  <= 1'b0;
    end else begin
      s1  <= noisy;
      s2  <= s1;
      pos <= 1'b0;
      neg <= 1'b0;
      if (s2 == cond) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // s2 has disagreed with cond for DEBOUNCE consecutive cycles
        cond <= s2;
        cnt  <= '0;
        pos  <= s2;
        neg  <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conditioned_shift_frontend.sv
// Conditioned serial front end: three debounced input channels driving a
// shift register with parallel load, selectable shift edge and bit order.
module conditioned_shift_frontend
  import conditioned_shift_frontend_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned DEBOUNCE      = DEF_DEBOUNCE,
  parameter bit          SHIFT_ON_FALL = DEF_SHIFT_ON_FALL,
  parameter bit          LSB_FIRST     = DEF_LSB_FIRST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_noisy,
  input  logic             sdi_noisy,
  input  logic             load_noisy,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic             frame_done,
  output logic [2:0]       cond_out
);

  localparam int unsigned   BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [NUM_CH-1:0] noisyVec;
  logic [NUM_CH-1:0] condVec;
  logic [NUM_CH-1:0] posVec;
  logic [NUM_CH-1:0] negVec;

  logic [WIDTH-1:0] shiftReg;
  logic [BW-1:0]    bitCnt;
  logic             frameDone;
  logic             shiftEvt;
  logic             loadEvt;
  logic             sdiCond;

  assign noisyVec[CH_SCLK] = sclk_noisy;
  assign noisyVec[CH_SDI]  = sdi_noisy;
  assign noisyVec[CH_LOAD] = load_noisy;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChan
    input_conditioner_p #(
      .DEBOUNCE(DEBOUNCE)
    ) uCond (
      .clk  (clk),
      .reset(reset),
      .noisy(noisyVec[ch]),
      .cond (condVec[ch]),
      .pos  (posVec[ch]),
      .neg  (negVec[ch])
    );
  end

  assign shiftEvt = SHIFT_ON_FALL ? negVec[CH_SCLK] : posVec[CH_SCLK];
  assign loadEvt  = negVec[CH_LOAD];
  assign sdiCond  = condVec[CH_SDI];

  // A load in the same cycle as a shift wins; the shift is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg  <= '0;
      bitCnt    <= '0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      if (loadEvt) begin
        shiftReg <= parallel_in;
        bitCnt   <= '0;
      end else if (shiftEvt) begin
        if (LSB_FIRST) begin
          shiftReg <= {sdiCond, shiftReg[WIDTH-1:1]};
        end else begin
          shiftReg <= {shiftReg[WIDTH-2:0], sdiCond};
        end
        if (bitCnt == BIT_LAST) begin
          bitCnt    <= '0;
          frameDone <= 1'b1;
        end else begin
          bitCnt <= bitCnt + BW'(1);
        end
      end
    end
  end

  assign parallel_out = shiftReg;
  assign serial_out   = LSB_FIRST ? shiftReg[0] : shiftReg[WIDTH-1];
  assign frame_done   = frameDone;
  assign cond_out     = condVec;

endmodule

// File: tb/tb_conditioned_shift_frontend.sv
// Checks two configurations (MSB-first/rise and LSB-first/fall) of the
// conditioned shift front end against a history-based behavioural model.
module tb_conditioned_shift_frontend;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclkN, sdiN, loadN;
  logic [W-1:0] par;
  logic [W-1:0] po0, po1;
  logic         so0, so1, fd0, fd1;
  logic [2:0]   co0, co1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  conditioned_shift_frontend #(
    .WIDTH(W), .DEBOUNCE(D), .SHIFT_ON_FALL(1'b0), .LSB_FIRST(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .sclk_noisy(sclkN), .sdi_noisy(sdiN),
    .load_noisy(loadN), .parallel_in(par), .parallel_out(po0),
    .serial_out(so0), .frame_done(fd0), .cond_out(co0)
  );

  conditioned_shift_frontend #(
    .WIDTH(W), .DEBOUNCE(D), .SHIFT_ON_FALL(1'b1), .LSB_FIRST(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .sclk_noisy(sclkN), .sdi_noisy(sdiN),
    .load_noisy(loadN), .parallel_in(par), .parallel_out(po1),
    .serial_out(so1), .frame_done(fd1), .cond_out(co1)
  );

  // ---------------- behavioural model ----------------
  // Pin samples reach the debouncer two edges late; a level is accepted once
  // the last D delayed samples all disagree with the current conditioned level.
  bit [2:0]     p1, p2, mc, posPrev, negPrev;
  bit           win[3][$];
  logic [W-1:0] msr[2];
  int unsigned  mn[2];
  bit           mfd[2];

  task automatic modelEdge();
    bit [2:0] pin;
    bit [2:0] posNow, negNow;
    bit       shift, load, agree;
    pin = {loadN, sdiN, sclkN};
    if (reset) begin
      p1 = '0; p2 = '0; mc = '0; posPrev = '0; negPrev = '0;
      for (int ch = 0; ch < 3; ch++) win[ch].delete();
      for (int d = 0; d < 2; d++) begin
        msr[d] = '0; mn[d] = 0; mfd[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        shift  = (d == 1) ? negPrev[0] : posPrev[0];
        load   = negPrev[2];
        mfd[d] = 1'b0;
        if (load) begin
          msr[d] = par;
          mn[d]  = 0;
        end else if (shift) begin
          if (d == 1) msr[d] = {mc[1], msr[d][W-1:1]};
          else        msr[d] = {msr[d][W-2:0], mc[1]};
          mn[d]++;
          if (mn[d] == W) begin
            mn[d]  = 0;
            mfd[d] = 1'b1;
          end
        end
      end
      posNow = '0;
      negNow = '0;
      for (int ch = 0; ch < 3; ch++) begin
        win[ch].push_back(p2[ch]);
        if (win[ch].size() > D) void'(win[ch].pop_front());
        agree = (win[ch].size() == D);
        foreach (win[ch][i]) if (win[ch][i] == mc[ch]) agree = 1'b0;
        if (agree) begin
          mc[ch]     = ~mc[ch];
          posNow[ch] = mc[ch];
          negNow[ch] = ~mc[ch];
          win[ch].delete();
        end
        p2[ch] = p1[ch];
        p1[ch] = pin[ch];
      end
      posPrev = posNow;
      negPrev = negNow;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  int fdCnt0 = 0, fdCnt1 = 0, rise0 = 0, fall0 = 0;
  logic prevSclkCond = 1'b0;

  // one clock: model advances on the edge, DUT outputs compared 1 time unit later
  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    chk("po0", 32'(po0), 32'(msr[0]));
    chk("so0", 32'(so0), 32'(msr[0][W-1]));
    chk("fd0", 32'(fd0), 32'(mfd[0]));
    chk("co0", 32'(co0), 32'(mc));
    chk("po1", 32'(po1), 32'(msr[1]));
    chk("so1", 32'(so1), 32'(msr[1][0]));
    chk("fd1", 32'(fd1), 32'(mfd[1]));
    chk("co1", 32'(co1), 32'(mc));
    if (fd0 === 1'b1) fdCnt0++;
    if (fd1 === 1'b1) fdCnt1++;
    if (co0[0] === 1'b1 && prevSclkCond === 1'b0) rise0++;
    if (co0[0] === 1'b0 && prevSclkCond === 1'b1) fall0++;
    prevSclkCond = co0[0];
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sclkPulse();
    sclkN = 1'b1; hold(6);
    sclkN = 1'b0; hold(6);
  endtask

  task automatic loadPulse(input logic [W-1:0] v);
    par = v;
    loadN = 1'b1; hold(8);
    loadN = 1'b0; hold(8);
  endtask

  int base, rBase, fBase;
  logic [7:0] bits;

  initial begin
    // reset with every pin high
    reset = 1'b1; sclkN = 1'b1; sdiN = 1'b1; loadN = 1'b1; par = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_po", 32'(po0), 32'h0);
      chk("rst_co", 32'(co0), 32'h0);
      chk("rst_fd", 32'(fd0), 32'h0);
    end
    reset = 1'b0;
    tick();
    chk("post_rst_po", 32'(po0), 32'h0);
    chk("post_rst_so", 32'(so0), 32'h0);
    chk("post_rst_co", 32'(co1), 32'h0);
    sclkN = 1'b0; sdiN = 1'b0; loadN = 1'b0;
    hold(14);

    // glitches on sclk: only the final stable high is accepted
    rBase = rise0; fBase = fall0;
    sclkN = 1'b1; tick(); sclkN = 1'b0; tick();
    sclkN = 1'b1; tick(); sclkN = 1'b0; tick();
    sclkN = 1'b1;
    hold(4);
    chk("deb_before", 32'(co0[0]), 32'h0);
    tick();
    chk("deb_at_lat", 32'(co0[0]), 32'h1);
    hold(6);
    chk("deb_rises", 32'(rise0 - rBase), 32'd1);
    chk("deb_falls", 32'(fall0 - fBase), 32'd0);
    sclkN = 1'b0; hold(8);

    // parallel load
    base = fdCnt0;
    loadPulse(8'hA5);
    chk("load_po0", 32'(po0), 32'hA5);
    chk("load_so0", 32'(so0), 32'h1);
    chk("load_so1", 32'(so1), 32'h1);
    chk("load_nofd", 32'(fdCnt0 - base), 32'd0);

    // MSB-first frame of 1,0,1,1,0,0,1,0
    loadPulse(8'h00);
    base = fdCnt0;
    bits = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      sdiN = bits[i]; hold(6);
      sclkPulse();
    end
    chk("frame_po0", 32'(po0), 32'hB2);
    chk("frame_fd", 32'(fdCnt0 - base), 32'd1);
    sdiN = 1'b1; hold(6);
    sclkPulse();
    chk("wrap_po0", 32'(po0), 32'h65);
    chk("wrap_nofd", 32'(fdCnt0 - base), 32'd1);

    // LSB-first on falling edges
    loadPulse(8'h81);
    sdiN = 1'b0; hold(6);
    for (int i = 0; i < 4; i++) sclkPulse();
    chk("lsb_po1", 32'(po1), 32'h08);
    chk("lsb_so1", 32'(so1), 32'h0);

    // load and shift events land on the same cycle
    par = 8'h3C; loadN = 1'b1; hold(8);
    sclkN = 1'b1; loadN = 1'b0; hold(8);
    chk("coll_po0", 32'(po0), 32'h3C);
    chk("coll_po1", 32'(po1), 32'h3C);
    sclkN = 1'b0; sdiN = 1'b1; hold(8);
    for (int i = 0; i < 5; i++) sclkPulse();
    reset = 1'b1; hold(2);
    reset = 1'b0; hold(8);
    base = fdCnt0;
    for (int i = 0; i < 7; i++) sclkPulse();
    chk("rst_frame_7", 32'(fdCnt0 - base), 32'd0);
    sclkPulse();
    chk("rst_frame_8", 32'(fdCnt0 - base), 32'd1);

    // random pin activity, including short glitches and occasional resets
    for (int i = 0; i < 300; i++) begin
      sclkN = 1'($urandom);
      sdiN  = 1'($urandom);
      loadN = ($urandom_range(0, 3) == 0) ? ~loadN : loadN;
      par   = W'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      hold($urandom_range(1, 8));
      reset = 1'b0;
    end
    hold(10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
